// File: rtl/stack_responder.sv
// stack_responder: LIFO responder for the push/pop handshake used by the
// recursive Fibonacci controller. Each push/pop request gets exactly one
// readySig pulse; initLd preloads a frame silently.
// Optional: define STACK_PEAK_EN to add the peakDepth profiling output.
module stack_responder #(
    parameter int FRAME_W = 24,
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pushSig,
    input  logic               popSig,
    input  logic               initLd,
    input  logic [FRAME_W-1:0] dataIn,
    output logic [FRAME_W-1:0] dataOut,
    output logic               readySig,
    output logic               empty,
    output logic               full,
    output logic               finish,
    output logic               overflow,
    output logic               underflow,
    output logic               protoErr,
`ifdef STACK_PEAK_EN
    output logic [ADDR_W:0]    peakDepth,
`endif
    output logic [ADDR_W:0]    depth
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

    localparam logic [ADDR_W:0] SP_MAX = (ADDR_W+1)'(DEPTH);

    state_t             state, state_nx;
    logic [ADDR_W:0]    sp;
    logic [FRAME_W-1:0] mem [DEPTH];
    logic [FRAME_W-1:0] frame_q;

    logic               do_init, do_latch, wr_try, wr_en, rd_ok, rd_empty;
    logic [FRAME_W-1:0] wr_data;
    logic [ADDR_W-1:0]  wr_addr, rd_addr;

    assign empty = (sp == '0);
    assign full  = (sp == SP_MAX);
    assign depth = sp;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next state: requests are looked at only in IDLE; initLd stays in IDLE
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (initLd)       state_nx = IDLE;
                else if (pushSig) state_nx = WRITE;
                else if (popSig)  state_nx = READ;
            end
            WRITE:   state_nx = DONE;
            READ:    state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath strobes decoded from the current state
    always_comb begin
        do_init  = (state == IDLE) && initLd;
        do_latch = (state == IDLE) && !initLd && pushSig;
        wr_try   = do_init || (state == WRITE);
        wr_en    = wr_try && !full;
        wr_data  = do_init ? dataIn : frame_q;
        rd_ok    = (state == READ) && !empty;
        rd_empty = (state == READ) && empty;
        wr_addr  = sp[ADDR_W-1:0];
        rd_addr  = ADDR_W'(sp - 1'b1);
    end

    // Frame storage; contents need no reset
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Push frame is captured in IDLE so the requester may change dataIn later
    always_ff @(posedge clk) begin
        if (do_latch) frame_q <= dataIn;
    end

    // Stack pointer: saturates at both ends instead of wrapping
    always_ff @(posedge clk) begin
        if (rst)        sp <= '0;
        else if (wr_en) sp <= sp + 1'b1;
        else if (rd_ok) sp <= sp - 1'b1;
    end

    // Pop result, completion pulses and sticky error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            dataOut   <= '0;
            readySig  <= 1'b0;
            finish    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            protoErr  <= 1'b0;
        end else begin
            readySig <= (state_nx == DONE);
            finish   <= rd_empty;
            if (rd_ok)         dataOut <= mem[rd_addr];
            else if (rd_empty) dataOut <= '0;
            if (wr_try && full) overflow  <= 1'b1;
            if (rd_empty)       underflow <= 1'b1;
            if ((state == IDLE) && pushSig && popSig) protoErr <= 1'b1;
        end
    end

`ifdef STACK_PEAK_EN
    // High-water mark of sp since the last reset
    always_ff @(posedge clk) begin
        if (rst)                 peakDepth <= '0;
        else if (sp > peakDepth) peakDepth <= sp;
    end
`endif

endmodule

// File: doc/stack_responder.md
Name: stack_responder

Overview:
- Stack-side responder for the push/pop handshake issued by the recursive-computation controller (Fibonacci datapath).
- Holds call frames {n, flag, res} in a LIFO and answers every pushSig/popSig request with exactly one readySig pulse.
- On pop, it returns the top frame on dataOut.
- Also supports preloading the initial frame and reports when the computation unwinds to an empty stack.

Parameters:
- FRAME_W, 24, frame width in bits; the controller packs {n[7:0], flag[7:0], res[7:0]}.
- DEPTH, 16, number of frames; must be a power of two.
- ADDR_W, 4, log2(DEPTH).

Ports:
- clk  input  1  rising-edge clock, sole clock domain.
- rst  input  1  synchronous, active-high reset.
- pushSig  input  1  push request, held high by the requester until readySig.
- popSig  input  1  pop request, held high by the requester until readySig.
- initLd  input  1  preload request; pushes dataIn like a push but does not pulse readySig.
- dataIn  input  FRAME_W  frame to push; sampled in the IDLE accept cycle.
- dataOut  output  FRAME_W  frame returned by the last pop; held until the next pop completes.
- readySig  output  1  one-cycle completion pulse for push/pop.
- empty  output  1  sp == 0.
- full  output  1  sp == DEPTH.
- finish  output  1  one-cycle pulse when a pop is attempted on an empty stack.
- overflow  output  1  sticky; set by a push or initLd while full.
- underflow  output  1  sticky; set by a pop while empty.
- protoErr  output  1  sticky; set when pushSig and popSig are both high in IDLE.
- depth  output  ADDR_W+1  current sp.

Behaviour:
- Reset (rst=1 at a clk edge, whether idle or mid-operation):
  - state=IDLE, sp=0.
  - dataOut=0, readySig=0, finish=0, overflow=0, underflow=0, protoErr=0.
  - Memory contents are don't-care.
  - Any in-flight operation is abandoned with no readySig.
- FSM states IDLE, WRITE, READ, DONE. Requests are sampled only in IDLE.
- IDLE priority: initLd > pushSig > popSig.
- initLd:
  - Not full: mem[sp]<=dataIn, sp<=sp+1, stay IDLE, no readySig.
  - Full: overflow<=1, no write.
- pushSig:
  - Latch dataIn, go to WRITE.
  - WRITE, not full: mem[sp]<=latched frame, sp<=sp+1.
  - WRITE, full: overflow<=1, sp unchanged, frame dropped.
  - Then go to DONE.
- popSig:
  - Go to READ.
  - READ, not empty: dataOut<=mem[sp-1], sp<=sp-1.
  - READ, empty: dataOut<=0, underflow<=1, finish<=1 for the DONE cycle.
  - Then go to DONE.
- pushSig and popSig both high in IDLE: protoErr<=1, push is served, pop is ignored (the requester re-asserts it later).
- DONE: readySig=1 for exactly this cycle, then return to IDLE. Requests present during DONE are not sampled. This makes a request held through the readySig edge complete exactly once.
- Latency: a request high in IDLE cycle t produces readySig in cycle t+2. Back-to-back operations are spaced 3 cycles apart (IDLE, op, DONE).
- Registered outputs:
  - readySig and finish are registered.
  - dataOut is stable from the DONE cycle until the next READ completes; a push does not change it.
  - empty, full and depth are combinational from sp and update the cycle after sp changes.
- Sticky flags clear only on rst.
- sp never exceeds DEPTH and never goes below 0: no wrap-around.

Optional Feature:
- Macro STACK_PEAK_EN.
- When defined: adds output peakDepth[ADDR_W+1].
  - Reset to 0.
  - Updated to sp whenever sp exceeds it; monotonic until rst.
  - Used for profiling recursion depth.
- When undefined: the port and its register are absent; all other behaviour is identical.

Test Plan:
- Push/pop LIFO: initLd 0x050000, then push 0x040100 and push 0x030100; three pops return 0x030100, 0x040100, 0x050000 in that order. readySig arrives 2 cycles after each request, depth ends at 0.
- Hold semantics: keep popSig high for 4 cycles after readySig with 2 frames stored -> exactly one pop per accepted IDLE sample, and each frame is popped once per readySig.
- Full boundary (DEPTH=16): 16 pushes, then a 17th push -> readySig still pulses, overflow=1, depth=16, top frame unchanged on the next pop.
- Empty boundary: pop with sp=0 -> readySig=1 and finish=1 in the same cycle, dataOut=0, underflow=1, depth stays 0.
- Simultaneous request: pushSig=popSig=1 in IDLE -> protoErr=1, depth increments by 1, single readySig.
- Reset mid-operation: assert rst in WRITE during a push with depth=3 -> next cycle depth=0, no readySig, all flags 0. Under STACK_PEAK_EN, peakDepth reads 0 after reset and reads 3 after three subsequent pushes.
